icache_direct: RTL
==================

// Module: icache_direct
// PURPOSE
// - Direct-mapped instruction cache between the fetch unit and the memory controller.
// - Serves 32-bit instruction reads.
// - On a miss, requests one 16-byte line from the memory controller's icache port.
//   The controller returns the whole line as one 128-bit word with a one-cycle ready pulse.
// PARAMETERS
// - ADDR_WIDTH   32  byte-address width.
// - INDEX_BITS   4   line-index bits; 2**INDEX_BITS lines.
// - Line size is fixed at 16 B (offset bits [3:0]).
// - TAG_BITS = ADDR_WIDTH-INDEX_BITS-4.
// PORTS
// - clk             in   1           clock, rising edge.
// - rst             in   1           reset; asynchronous, active-low.
// - rdy             in   1           global enable; when low, all state and outputs hold.
// - pc_from_ifu     in   ADDR_WIDTH  fetch address; bits [1:0] ignored.
// - valid_from_ifu  in   1           fetch request; sampled only in IDLE.
// - clear_from_rob  in   1           flush: pending fetch result is discarded.
// - inst_to_ifu     out  32          fetched instruction.
// - ready_to_ifu    out  1           one-cycle pulse; inst_to_ifu valid in that cycle.
// - addr_to_mem     out  ADDR_WIDTH  line address; [3:0] always 0.
// - valid_to_mem    out  1           line-fill request.
// - data_from_mem   in   128         line data; byte k at bits [8k+7:8k].
// - ready_from_mem  in   1           one-cycle pulse; data_from_mem valid in that cycle.
// BEHAVIOUR
// - Reset (rst=0, async):
//   - all valid bits cleared; state=IDLE.
//   - ready_to_ifu=0, valid_to_mem=0, addr_to_mem=0, inst_to_ifu=0.
//   - tag and data arrays are not reset.
// - FSM state IDLE:
//   - On valid_from_ifu && !clear_from_rob, latch pc.
//   - Hit (valid[idx] && tag[idx]==pc tag): go to RESP.
//   - Miss: go to MISS; valid_to_mem=1 and addr_to_mem={pc[ADDR_WIDTH-1:4],4'b0} from the next cycle.
// - FSM state RESP:
//   - ready_to_ifu=1 for one cycle.
//   - inst_to_ifu = line word pc[3:2], little-endian.
//   - Return to IDLE; a new request is accepted no earlier than the cycle after the pulse.
//   - Hit latency: request edge to ready_to_ifu = 1 cycle.
// - FSM state MISS:
//   - valid_to_mem and addr_to_mem are held stable until ready_from_mem is sampled high.
//   - On that edge: valid_to_mem<=0, the line is written, tag is written, valid[idx]<=1; go to RESP.
//   - valid_to_mem is never high in the cycle after ready_from_mem (no re-request).
// - clear_from_rob:
//   - In RESP: suppresses ready_to_ifu; goto IDLE.
//   - In MISS: the request is NOT withdrawn; the line is still filled on ready_from_mem.
//     The FSM then returns to IDLE without a response (sticky drop flag).
//   - In IDLE: blocks acceptance that cycle.
// - Simultaneous clear_from_rob and ready_from_mem in MISS: fill occurs, no response.
// - rdy=0 mid-miss: FSM frozen; the memory controller is also frozen, so the handshake resumes intact.
// - Reset mid-miss: the request drops immediately. The memory-controller reset is shared, so no orphan transfer remains.
// - Index wrap: addresses differing only in tag map to the same line; a fill overwrites it.
// CONFIGURATION
// - ICACHE_PERF_CNT_EN defined:
//   - Adds outputs hit_cnt[31:0] and miss_cnt[31:0], reset to 0.
//   - Each counter increments once per accepted request classified as hit or miss; flushed requests are counted.
//   - Counters wrap at 2**32.
// - ICACHE_PERF_CNT_EN undefined: the ports and counters are absent; the rest of the behaviour is identical.
// TESTING
// - Cold miss:
//   - Stimulus: pc=0x0000_1004; mem returns line 0x...DDDDCCCCBBBBAAAA after 18 cycles.
//   - Expect: addr_to_mem=0x1000; one valid_to_mem period; ready_to_ifu one cycle after fill; inst=0xBBBBBBBB.
// - Hit:
//   - Stimulus: pc=0x0000_100C after the previous test.
//   - Expect: ready_to_ifu 1 cycle after request, inst=0xDDDDDDDD, valid_to_mem stays 0.
// - Conflict:
//   - Stimulus: pc=0x0000_1100 (same index, INDEX_BITS=4), then 0x0000_1004.
//   - Expect: both miss; 2 memory requests total.
// - Flush in MISS:
//   - Stimulus: clear_from_rob pulse 3 cycles after a miss on 0x2000.
//   - Expect: valid_to_mem held until ready_from_mem; no ready_to_ifu; a later pc=0x2000 hits.
// - rdy stall + reset:
//   - Stimulus: rdy=0 for 5 cycles during MISS, then rst=0 asynchronously.
//   - Expect: outputs frozen during the stall; valid_to_mem/ready_to_ifu drop at once on reset; a post-reset access misses.
// - ICACHE_PERF_CNT_EN:
//   - Stimulus: 3 misses then 5 hits.
//   - Expect: miss_cnt=3, hit_cnt=5.

Source files
------------

// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// slave = the cache; master = the fetch unit / memory controller side.
interface icache_direct_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] pc_from_ifu;
  logic                  valid_from_ifu;
  logic                  clear_from_rob;
  logic [31:0]           inst_to_ifu;
  logic                  ready_to_ifu;
  logic [ADDR_WIDTH-1:0] addr_to_mem;
  logic                  valid_to_mem;
  logic [127:0]          data_from_mem;
  logic                  ready_from_mem;

  modport slave (
    input  pc_from_ifu, valid_from_ifu, clear_from_rob, data_from_mem, ready_from_mem,
    output inst_to_ifu, ready_to_ifu, addr_to_mem, valid_to_mem
  );

  modport master (
    output pc_from_ifu, valid_from_ifu, clear_from_rob, data_from_mem, ready_from_mem,
    input  inst_to_ifu, ready_to_ifu, addr_to_mem, valid_to_mem
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped I-cache, 16 B lines filled as one 128-bit beat from the memory controller.
// Define ICACHE_PERF_CNT_EN to add the hit_cnt / miss_cnt performance counters.
module icache_direct #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  icache_direct_if.slave    bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 4;

  typedef enum logic [1:0] {IDLE, RESP, MISS} state_e;

  state_e                state_q;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [127:0]          data_q [LINES];
  logic [ADDR_WIDTH-1:2] pc_q;
  logic                  drop_q, ready_q, vmem_q;
  logic [31:0]           inst_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic [INDEX_BITS-1:0] req_idx, miss_idx;
  logic [TAG_BITS-1:0]   req_tag, miss_tag;
  logic                  req_hit, accept, fill;

  function automatic logic [31:0] word_sel(input logic [127:0] line, input logic [1:0] w);
    return line[{w, 5'b0} +: 32];
  endfunction

  assign req_idx  = bus.pc_from_ifu[INDEX_BITS+3:4];
  assign req_tag  = bus.pc_from_ifu[ADDR_WIDTH-1:INDEX_BITS+4];
  assign miss_idx = pc_q[INDEX_BITS+3:4];
  assign miss_tag = pc_q[ADDR_WIDTH-1:INDEX_BITS+4];
  assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign accept   = rdy && (state_q == IDLE) && bus.valid_from_ifu && !bus.clear_from_rob;
  assign fill     = rdy && (state_q == MISS) && bus.ready_from_mem;

  // A flush landing in the response cycle kills the pulse without waiting a cycle.
  assign bus.ready_to_ifu = ready_q & ~bus.clear_from_rob;
  assign bus.inst_to_ifu  = inst_q;
  assign bus.addr_to_mem  = addr_q;
  assign bus.valid_to_mem = vmem_q;

  // Tag and data storage carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= bus.data_from_mem;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      pc_q    <= '0;
      drop_q  <= 1'b0;
      ready_q <= 1'b0;
      vmem_q  <= 1'b0;
      inst_q  <= '0;
      addr_q  <= '0;
    end else if (rdy) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            pc_q <= bus.pc_from_ifu[ADDR_WIDTH-1:2];
            if (req_hit) begin
              state_q <= RESP;
              ready_q <= 1'b1;
              inst_q  <= word_sel(data_q[req_idx], bus.pc_from_ifu[3:2]);
            end else begin
              state_q <= MISS;
              vmem_q  <= 1'b1;
              addr_q  <= {bus.pc_from_ifu[ADDR_WIDTH-1:4], 4'b0};
              drop_q  <= 1'b0;
            end
          end
        end
        RESP: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
        MISS: begin
          // The fill is never withdrawn; a flush only drops the response.
          if (bus.clear_from_rob) drop_q <= 1'b1;
          if (bus.ready_from_mem) begin
            vmem_q            <= 1'b0;
            valid_q[miss_idx] <= 1'b1;
            if (drop_q || bus.clear_from_rob) begin
              state_q <= IDLE;
            end else begin
              state_q <= RESP;
              ready_q <= 1'b1;
              inst_q  <= word_sel(bus.data_from_mem, pc_q[3:2]);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (req_hit) hit_cnt  <= hit_cnt + 32'd1;
      else         miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif
endmodule
